// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS boot-time program loader.
// Holds the loader state encoding, the default frame sync byte and the
// HALT opcode that test images use as their last instruction.
package mips_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_LEN_LO = 3'd3,
    ST_DATA   = 3'd4,
    ST_CSUM   = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } ld_state_e;

  localparam logic [7:0]  MAGIC_DEFAULT = 8'hA5;
  localparam logic [31:0] HALT_OPCODE   = 32'hfc000000;

  // States in which the loader owns the byte stream.
  function automatic logic st_is_busy(input ld_state_e s);
    return (s == ST_SYNC) || (s == ST_LEN_HI) || (s == ST_LEN_LO) ||
           (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/mips_byte_packer.sv
// Byte-to-word packer for the program loader.
// Shifts bytes MSB-first into a 32-bit word, keeps a running XOR of every
// byte it takes, and pulses word_valid the cycle after the 4th byte.
// Ports:
//   clk1, rst_n   clock, async active-low reset
//   clr           synchronous clear of counter, word, checksum and pulse
//   byte_en       accept byte_in this cycle
//   byte_in       data byte
//   word_valid    one-cycle pulse, word holds a complete word
//   word          assembled 32-bit word (big-endian)
//   csum          XOR of all bytes since the last clear
//   last_byte     next accepted byte completes a word
module mips_byte_packer (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word,
  output logic [7:0]  csum,
  output logic        last_byte
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  csum_q, csum_d;
  logic        wv_q, wv_d;

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    csum_d = csum_q;
    wv_d   = 1'b0;
    if (clr) begin
      cnt_d  = 2'd0;
      word_d = 32'd0;
      csum_d = 8'd0;
    end else if (byte_en) begin
      cnt_d  = cnt_q + 2'd1;
      word_d = {word_q[23:0], byte_in};
      csum_d = csum_q ^ byte_in;
      wv_d   = (cnt_q == 2'd3);
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 2'd0;
      word_q <= 32'd0;
      csum_q <= 8'd0;
      wv_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
      csum_q <= csum_d;
      wv_q   <= wv_d;
    end
  end

  assign word_valid = wv_q;
  assign word       = word_q;
  assign csum       = csum_q;
  assign last_byte  = (cnt_q == 2'd3);

endmodule

// File: rtl/mips_prog_loader.sv
// Boot-time program loader: parses a framed byte stream
// (MAGIC, LEN_HI, LEN_LO, LEN x 4 data bytes, CSUM), writes each word into
// instruction memory and releases the CPU once the XOR checksum matches.
// Ports:
//   clk1, rst_n         clock, async active-low reset
//   start               one-cycle pulse starting a session (ignored while busy)
//   in_valid/in_data    byte stream, accepted on in_valid & in_ready
//   in_ready            loader takes a byte this cycle
//   mem_we/addr/wdata   one-cycle word write to memory
//   cpu_run             processor release
//   busy, done, err     session status (done/err hold until next start)
//   words_loaded        words written this session
module mips_prog_loader
  import mips_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int          DEPTH     = 1024,
  parameter int          BASE_ADDR = 0,
  parameter logic [7:0]  MAGIC     = MAGIC_DEFAULT
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_run,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_1  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   WL_1    = (ADDR_W+1)'(1);
  localparam logic [16:0]       DEPTH_L = 17'(DEPTH);

  ld_state_e         state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       words_rx_q, words_rx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   wl_q, wl_d;

  logic        accept;
  logic        pk_clr;
  logic        pk_en;
  logic        pk_word_valid;
  logic [31:0] pk_word;
  logic [7:0]  pk_csum;
  logic        pk_last_byte;
  logic [15:0] len_in;

  assign in_ready = st_is_busy(state_q);
  assign accept   = in_valid & in_ready;
  assign pk_en    = accept && (state_q == ST_DATA);
  assign len_in   = {len_hi_q, in_data};

  mips_byte_packer u_packer (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .clr        (pk_clr),
    .byte_en    (pk_en),
    .byte_in    (in_data),
    .word_valid (pk_word_valid),
    .word       (pk_word),
    .csum       (pk_csum),
    .last_byte  (pk_last_byte)
  );

  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    len_d      = len_q;
    words_rx_d = words_rx_q;
    addr_d     = addr_q;
    wl_d       = wl_q;
    pk_clr     = 1'b0;

    // Address advances after the strobe cycle so mem_addr is stable during it.
    if (pk_word_valid) begin
      addr_d = addr_q + ADDR_1;
      wl_d   = wl_q + WL_1;
    end

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_SYNC;
          pk_clr     = 1'b1;
          addr_d     = BASE;
          wl_d       = '0;
          words_rx_d = 16'd0;
          len_d      = 16'd0;
          len_hi_d   = 8'd0;
        end
      end
      ST_SYNC: begin
        if (accept && (in_data == MAGIC)) state_d = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_hi_d = in_data;
          state_d  = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          len_d = len_in;
          if ({1'b0, len_in} > DEPTH_L) state_d = ST_ERR;
          else if (len_in == 16'd0)      state_d = ST_CSUM;
          else                           state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept && pk_last_byte) begin
          words_rx_d = words_rx_q + 16'd1;
          if ((words_rx_q + 16'd1) == len_q) state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        // The last word's checksum contribution is already registered here.
        if (accept) state_d = (in_data == pk_csum) ? ST_DONE : ST_ERR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      len_hi_q   <= 8'd0;
      len_q      <= 16'd0;
      words_rx_q <= 16'd0;
      addr_q     <= BASE;
      wl_q       <= '0;
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      len_q      <= len_d;
      words_rx_q <= words_rx_d;
      addr_q     <= addr_d;
      wl_q       <= wl_d;
    end
  end

  assign mem_we       = pk_word_valid;
  assign mem_addr     = addr_q;
  assign mem_wdata    = pk_word;
  assign busy         = in_ready;
  assign done         = (state_q == ST_DONE);
  assign err          = (state_q == ST_ERR);
  assign cpu_run      = (state_q == ST_DONE);
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_mips_prog_loader.sv
module tb_mips_prog_loader;
  import mips_pkg::*;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_run;
  logic        busy;
  logic        done;
  logic        err;
  logic [10:0] words_loaded;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int hs_cyc = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];

  logic [31:0] prog[9] = '{32'h2801000a, 32'h28020014, 32'h28030019,
                           32'h0ce77800, 32'h0ce77800, 32'h00222000,
                           32'h0ce77800, 32'h00832800, HALT_OPCODE};

  mips_prog_loader dut (
    .clk1         (clk1),
    .rst_n        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_run      (cpu_run),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk1 = ~clk1;
  always @(posedge clk1) cyc++;

  always @(negedge clk1) begin
    if (mem_we) begin
      wr_addr.push_back(32'(mem_addr));
      wr_data.push_back(mem_wdata);
      wr_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk1); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    bit took;
    if (gaps) begin
      n = $urandom_range(0, 3);
      repeat (n) begin @(posedge clk1); #1; end
    end
    in_valid = 1'b1;
    in_data  = b;
    took = 1'b0;
    n = 0;
    while (!took && n < 50) begin
      took = in_ready;
      @(posedge clk1); #1;
      n++;
    end
    in_valid = 1'b0;
    hs_cyc = cyc;
    if (!took) chk("handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    send_byte(w[31:24], gaps);
    send_byte(w[23:16], gaps);
    send_byte(w[15:8], gaps);
    send_byte(w[7:0], gaps);
  endtask

  task automatic load_prog(input bit gaps);
    logic [7:0] cs;
    cs = 8'd0;
    for (int i = 0; i < 9; i++) cs = cs ^ prog[i][31:24] ^ prog[i][23:16] ^ prog[i][15:8] ^ prog[i][7:0];
    clear_log();
    pulse_start();
    send_byte(8'hA5, gaps);
    send_byte(8'h00, gaps);
    send_byte(8'h09, gaps);
    for (int i = 0; i < 9; i++) send_word(prog[i], gaps);
    send_byte(cs, gaps);
    repeat (2) begin @(posedge clk1); #1; end
    chk("prog_nwr", 32'(wr_addr.size()), 32'd9);
    for (int i = 0; i < 9 && i < wr_addr.size(); i++) begin
      chk($sformatf("prog_addr%0d", i), wr_addr[i], 32'(i));
      chk($sformatf("prog_data%0d", i), wr_data[i], prog[i]);
    end
    chk("prog_done", 32'(done), 32'd1);
    chk("prog_err", 32'(err), 32'd0);
    chk("prog_wl", 32'(words_loaded), 32'd9);
  endtask

  task automatic single_word(input logic [7:0] cs);
    int wcyc;
    clear_log();
    pulse_start();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h28, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h0A, 1'b0);
    wcyc = hs_cyc;
    send_byte(cs, 1'b0);
    repeat (2) begin @(posedge clk1); #1; end
    chk("sw_nwr", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() > 0) begin
      chk("sw_addr", wr_addr[0], 32'd0);
      chk("sw_data", wr_data[0], 32'h2801000a);
      chk("sw_wr_cycle", 32'(wr_cyc[0]), 32'(wcyc));
    end
  endtask

  initial begin
    #23;
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_status", {28'd0, cpu_run, busy, done, err}, 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_wl", 32'(words_loaded), 32'd0);
    @(posedge clk1); #1;
    rst_n = 1'b1;
    @(posedge clk1); #1;

    // Single word, good checksum 28^01^00^0A = 23
    single_word(8'h23);
    chk("sw_done", 32'(done), 32'd1);
    chk("sw_run", 32'(cpu_run), 32'd1);
    chk("sw_wl", 32'(words_loaded), 32'd1);
    chk("sw_err", 32'(err), 32'd0);
    chk("sw_busy", 32'(busy), 32'd0);

    load_prog(1'b0);
    load_prog(1'b1);

    // Bad checksum
    single_word(8'h24);
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_run", 32'(cpu_run), 32'd0);
    chk("bad_done", 32'(done), 32'd0);

    // Resync over garbage, zero-length frame
    clear_log();
    pulse_start();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_clr_err", 32'(err), 32'd0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h5A, 1'b0);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("zl_done", 32'(done), 32'd1);
    chk("zl_nwr", 32'(wr_addr.size()), 32'd0);
    chk("zl_wl", 32'(words_loaded), 32'd0);

    // Length 0x0401 exceeds depth
    pulse_start();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h01, 1'b0);
    chk("len_err", 32'(err), 32'd1);
    chk("len_ready", 32'(in_ready), 32'd0);
    repeat (3) begin @(posedge clk1); #1; end
    chk("len_nwr", 32'(wr_addr.size()), 32'd0);

    // Start while busy is ignored: session continues normally
    pulse_start();
    send_byte(8'hA5, 1'b0);
    pulse_start();
    chk("busy_start_ign", 32'(busy), 32'd1);

    // Reset mid-load after 6 data bytes
    clear_log();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_word(32'h11223344, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_status", {28'd0, cpu_run, busy, done, err}, 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_wl", 32'(words_loaded), 32'd0);
    repeat (3) begin @(posedge clk1); #1; end
    chk("mid_rst_nwr", 32'(wr_addr.size()), 32'd1);
    rst_n = 1'b1;
    @(posedge clk1); #1;

    single_word(8'h23);
    chk("reload_done", 32'(done), 32'd1);
    chk("reload_wl", 32'(words_loaded), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
